// File: rtl/mul_arbiter.sv
// Two-requester front end for a shared iterative multiplier.
// One operation is in flight at a time: a requester's operand pair is
// accepted in IDLE, issued to the multiplier, the product is held and
// returned to the requester that owns it, then the next request is accepted.
module mul_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    // requester 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [32:0] req0_src1,
    input  logic [32:0] req0_src2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_result,
    // requester 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [32:0] req1_src1,
    input  logic [32:0] req1_src2,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_result,
    // shared multiplier
    output logic        mul_in_valid,
    input  logic        mul_in_ready,
    output logic [32:0] mul_src1,
    output logic [32:0] mul_src2,
    input  logic        mul_out_valid,
    input  logic [63:0] mul_result,
    // status
    output logic [15:0] done0_cnt,
    output logic [15:0] done1_cnt,
    output logic        err_spurious
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] src1_q, src1_d;
    logic [32:0] src2_q, src2_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [63:0] hold_q, hold_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic        err_q, err_d;
    logic        mul_in_valid_q, mul_in_valid_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;

    logic [1:0]  grant_s;
    logic        idle_s;

    // One-hot grant: bit 0 = requester 0, bit 1 = requester 1.
    // With round-robin a tie goes to whoever was not granted last
    // (last = 1 means requester 1 went last, so requester 0 wins).
    function automatic logic [1:0] arb_grant(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1) begin
            if (RR_EN != 0) begin
                g = last ? 2'b01 : 2'b10;
            end else begin
                g = 2'b01;
            end
        end else if (v0) begin
            g = 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    // Arbitration decision and request-side ready outputs (only meaningful in IDLE).
    always_comb begin
        grant_s    = arb_grant(req0_valid, req1_valid, last_grant_q);
        idle_s     = (state_q == ST_IDLE);
        req0_ready = idle_s && grant_s[0] && !reset;
        req1_ready = idle_s && grant_s[1] && !reset;
    end

    // Next-state and datapath update for the single outstanding operation.
    always_comb begin
        state_d        = state_q;
        src1_d         = src1_q;
        src2_d         = src2_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        hold_d         = hold_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        err_d          = err_q;
        mul_in_valid_d = mul_in_valid_q;
        rsp0_valid_d   = rsp0_valid_q;
        rsp1_valid_d   = rsp1_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_s[0]) begin
                    src1_d         = req0_src1;
                    src2_d         = req0_src2;
                    owner_d        = 1'b0;
                    last_grant_d   = 1'b0;
                    mul_in_valid_d = 1'b1;
                    state_d        = ST_ISSUE;
                end else if (grant_s[1]) begin
                    src1_d         = req1_src1;
                    src2_d         = req1_src2;
                    owner_d        = 1'b1;
                    last_grant_d   = 1'b1;
                    mul_in_valid_d = 1'b1;
                    state_d        = ST_ISSUE;
                end else begin
                    state_d        = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mul_in_valid_q && mul_in_ready) begin
                    mul_in_valid_d = 1'b0;
                    state_d        = ST_BUSY;
                end else begin
                    state_d        = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (mul_out_valid) begin
                    hold_d       = mul_result;
                    rsp0_valid_d = (owner_q == 1'b0);
                    rsp1_valid_d = (owner_q == 1'b1);
                    state_d      = ST_RESP;
                end else begin
                    state_d      = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp0_valid_q && rsp0_ready) begin
                    cnt0_d       = cnt0_q + 16'd1;
                    rsp0_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (rsp1_valid_q && rsp1_ready) begin
                    cnt1_d       = cnt1_q + 16'd1;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_RESP;
                end
            end
            default: begin
                mul_in_valid_d = 1'b0;
                rsp0_valid_d   = 1'b0;
                rsp1_valid_d   = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase

        // A result pulse outside BUSY has no owner: flag it and never use its data.
        if (mul_out_valid && (state_q != ST_BUSY)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // State registers with synchronous reset; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            src1_q         <= 33'd0;
            src2_q         <= 33'd0;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            hold_q         <= 64'd0;
            cnt0_q         <= 16'd0;
            cnt1_q         <= 16'd0;
            err_q          <= 1'b0;
            mul_in_valid_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            src1_q         <= src1_d;
            src2_q         <= src2_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            hold_q         <= hold_d;
            cnt0_q         <= cnt0_d;
            cnt1_q         <= cnt1_d;
            err_q          <= err_d;
            mul_in_valid_q <= mul_in_valid_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
        end
    end

    assign mul_in_valid = mul_in_valid_q;
    assign mul_src1     = src1_q;
    assign mul_src2     = src2_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_result  = hold_q;
    assign rsp1_result  = hold_q;
    assign done0_cnt    = cnt0_q;
    assign done1_cnt    = cnt1_q;
    assign err_spurious = err_q;

endmodule
